ugshare_predictor: RTL
======================

# ugshare_predictor

Parametrised gshare micro-predictor for the IF0/IF1 fetch stages. It hashes the fetch PC with a speculative global history register (GHR) into a 2-bit saturating-counter PHT and returns a taken/not-taken prediction one cycle later. Every prediction is tracked in an in-flight FIFO until commit, which trains the PHT. A mispredict or flush restores the speculative GHR from a checkpoint or from the architectural GHR. The block sits beside the uBTB: the uBTB supplies hit and target, and this block supplies direction only.

## Interface
Parameters:
- MXLEN, 32, PC width.
- GHR_W, 10, history length; must satisfy GHR_W <= IDX_W.
- PHT_ENTRIES, 512, counter count; power of two; IDX_W = $clog2(PHT_ENTRIES).
- INFLIGHT_DEPTH, 8, in-flight FIFO entries; power of two, at least 2.
- CNT_RST, 2'b01, PHT reset value (weakly not-taken).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_pred_vld  in  1  prediction request.
- i_pred_pc  in  MXLEN  fetch PC.
- i_btb_hit  in  1  uBTB hit for i_pred_pc, same cycle as the request.
- o_pred_rdy  out  1  request can be accepted.
- o_pred_vld  out  1  response valid.
- o_pred_taken  out  1  predicted direction.
- o_pred_tag  out  $clog2(INFLIGHT_DEPTH)  FIFO slot allocated to this response.
- i_cmt_vld  in  1  commit of the oldest in-flight branch.
- i_cmt_taken  in  1  resolved direction.
- i_cmt_mispred  in  1  direction was mispredicted.
- i_flush  in  1  pipeline flush (exception/redirect not caused by this block).
- o_cmt_underflow  out  1  one-cycle pulse when a commit arrives with the FIFO empty.

## Operation
- Accept: a request is accepted when i_pred_vld && o_pred_rdy.
- o_pred_rdy = (fifo_count + pending_alloc) < INFLIGHT_DEPTH.
  - pending_alloc = accepted request with i_btb_hit still awaiting its response.
- Index: idx = i_pred_pc[IDX_W+1:2] ^ zero-extend(ghr_fwd).
  - ghr_fwd = the GHR value after any shift or restore taking effect at the same edge. This is a combinational bypass, so back-to-back requests see the previous prediction.
- PHT read is synchronous. The response at t+1 has o_pred_taken = cnt[1] && hit_q.
- Allocation: a response with hit_q:
  - pushes {idx, cnt, ghr_before} into the FIFO at tail, and o_pred_tag = tail;
  - shifts the speculative GHR: ghr <= {ghr[GHR_W-2:0], o_pred_taken}.
- A response without hit_q allocates nothing, leaves the GHR unchanged, and has o_pred_taken = 0.
- Commit (FIFO not empty): pop head and write the PHT at the stored idx.
  - New value = stored cnt saturating +1 if i_cmt_taken, saturating −1 otherwise; 11 stays at 11, 00 stays at 00.
  - arch_ghr <= {arch_ghr[GHR_W-2:0], i_cmt_taken}.
- Commit with mispredict:
  - after the pop, clear the FIFO (tail <= head+1, count <= 0);
  - ghr <= {stored ghr_before[GHR_W-2:0], i_cmt_taken};
  - squash any response due in the same or next cycle (o_pred_vld = 0, no allocation, no GHR shift).
- i_flush:
  - clears the FIFO and any pending response;
  - ghr <= arch_ghr, updated with the same-cycle commit if present;
  - the PHT write from a same-cycle commit still occurs.
- Priority for the GHR: flush > mispredict restore > allocation shift.
- PHT read/write to the same index in the same cycle: the read returns the old value.
- Commit while empty: ignored (no PHT or GHR change) and o_cmt_underflow = 1 for one cycle.

## Timing
- Reset values:
  - o_pred_vld 0, o_pred_taken 0, o_pred_tag 0, o_cmt_underflow 0, o_pred_rdy 1;
  - ghr 0, arch_ghr 0, FIFO empty, all PHT entries CNT_RST.
- Latency: request at edge t gives the response at t+1 (registered outputs).
- A commit at edge c writes the PHT, and the new value is visible to requests accepted at c+1 or later.
- Simultaneous allocate and non-mispredict commit leaves the count unchanged. Pointers wrap modulo INFLIGHT_DEPTH.
- Full FIFO: o_pred_rdy drops in the same cycle the last slot becomes reserved. A commit frees a slot, and o_pred_rdy rises in the next cycle.
- Reset asserted mid-operation returns everything to reset values asynchronously. No request is accepted while i_rstn = 0.

## Test plan
- After reset, a request for PC 0x100 with a hit gives o_pred_vld=1, o_pred_taken=0, o_pred_tag=0 at t+1, and ghr becomes 0.
- Train: three taken commits on the same idx take the counter 01→10→11→11. The next request to that idx gives o_pred_taken=1.
- Fill: 8 hit requests with no commits; o_pred_rdy=0 after the 8th is accepted. One commit raises rdy the next cycle, and the new tag is 0 (wrap).
- Mispredict: 4 in flight, GHR snapshot of the head 10'h155, commit taken with mispred. Result: ghr=10'h2AB, FIFO empty, and the same-cycle response is squashed.
- Flush with arch_ghr=10'h003 and a same-cycle taken commit: ghr=10'h007, FIFO empty, and the PHT entry is still incremented.
- Commit with the FIFO empty gives a one-cycle o_cmt_underflow, and PHT and GHR are unchanged.

Source files
------------

// File: rtl/ugshare_predictor.sv
// ugshare_predictor
// -----------------------------------------------------------------------------
// Gshare direction predictor for the IF0/IF1 fetch stages. The fetch PC is
// hashed with a speculative global history register (GHR) into a table of
// 2-bit saturating counters. The prediction is returned one cycle after the
// request. Every prediction that the uBTB marks as a hit is tracked in an
// in-flight FIFO until commit, which trains the table. A mispredict rewinds
// the speculative GHR from the snapshot stored with the committing branch. A
// flush reloads the speculative GHR from the architectural GHR.
//
// Ports
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_pred_vld/pc        prediction request and fetch PC
//   i_btb_hit            uBTB hit for the request PC, same cycle as the request
//   o_pred_rdy           a request can be accepted this cycle
//   o_pred_vld/taken/tag response one cycle after the request, with its FIFO slot
//   i_cmt_vld/taken      commit of the oldest in-flight branch, resolved direction
//   i_cmt_mispred        the committing branch was mispredicted
//   i_flush              pipeline flush from outside this block
//   o_cmt_underflow      one-cycle pulse after a commit that arrived with the FIFO empty
// -----------------------------------------------------------------------------
module ugshare_predictor #(
  parameter int         MXLEN          = 32,
  parameter int         GHR_W          = 10,
  parameter int         PHT_ENTRIES    = 512,
  parameter int         INFLIGHT_DEPTH = 8,
  parameter logic [1:0] CNT_RST        = 2'b01
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              i_pred_vld,
  input  logic [MXLEN-1:0]                  i_pred_pc,
  input  logic                              i_btb_hit,
  output logic                              o_pred_rdy,
  output logic                              o_pred_vld,
  output logic                              o_pred_taken,
  output logic [$clog2(INFLIGHT_DEPTH)-1:0] o_pred_tag,
  input  logic                              i_cmt_vld,
  input  logic                              i_cmt_taken,
  input  logic                              i_cmt_mispred,
  input  logic                              i_flush,
  output logic                              o_cmt_underflow
);

  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam int PTR_W = $clog2(INFLIGHT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;
  // A history longer than the index is folded down to its low IDX_W bits.
  localparam int XW    = (GHR_W > IDX_W) ? GHR_W : IDX_W;

  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    else    return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
  endfunction

  // Control state
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [GHR_W-1:0] arch_ghr_q, arch_ghr_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic             uflow_q, uflow_d;

  // Datapath state
  logic [1:0]       pht_q [PHT_ENTRIES];
  logic [IDX_W-1:0] fifo_idx_q [INFLIGHT_DEPTH];
  logic [1:0]       fifo_cnt_q [INFLIGHT_DEPTH];
  logic [GHR_W-1:0] fifo_ghr_q [INFLIGHT_DEPTH];
  logic [IDX_W-1:0] rsp_idx_q;
  logic [1:0]       rsp_cnt_q;

  logic [IDX_W-1:0] head_idx;
  logic [1:0]       head_cnt;
  logic [GHR_W-1:0] head_ghr;
  logic             fifo_nempty, cmt_fire, mis_fire, kill, push, accept;
  logic [OCC_W-1:0] occ;
  logic [XW-1:0]    ghr_x;
  logic [IDX_W-1:0] req_idx;
  logic             unused_bits;

  always_comb begin
    head_idx    = fifo_idx_q[head_q];
    head_cnt    = fifo_cnt_q[head_q];
    head_ghr    = fifo_ghr_q[head_q];
    fifo_nempty = (count_q != '0);
    cmt_fire    = i_cmt_vld & fifo_nempty;
    mis_fire    = cmt_fire & i_cmt_mispred;
    // A flush or a mispredict kills the response on the outputs right now as
    // well as any request accepted at the same edge.
    kill        = i_flush | mis_fire;

    occ          = OCC_W'(count_q) + OCC_W'(rsp_vld_q & rsp_hit_q);
    o_pred_rdy   = occ < OCC_W'(INFLIGHT_DEPTH);
    o_pred_vld   = rsp_vld_q & ~kill;
    o_pred_taken = o_pred_vld & rsp_hit_q & rsp_cnt_q[1];
    o_pred_tag   = tail_q;
    o_cmt_underflow = uflow_q;

    push   = o_pred_vld & rsp_hit_q;
    accept = i_pred_vld & o_pred_rdy;

    arch_ghr_d = cmt_fire ? {arch_ghr_q[GHR_W-2:0], i_cmt_taken} : arch_ghr_q;

    if (i_flush)       ghr_d = arch_ghr_d;
    else if (mis_fire) ghr_d = {head_ghr[GHR_W-2:0], i_cmt_taken};
    else if (push)     ghr_d = {ghr_q[GHR_W-2:0], o_pred_taken};
    else               ghr_d = ghr_q;

    head_d  = head_q + PTR_W'(cmt_fire);
    tail_d  = kill ? head_d : tail_q + PTR_W'(push);
    count_d = kill ? '0 : count_q + CNT_W'(push) - CNT_W'(cmt_fire);

    // The index sees the GHR as it will be after this edge, so a request
    // issued right behind a response already hashes with that prediction.
    ghr_x   = XW'(ghr_d);
    req_idx = i_pred_pc[IDX_W+1:2] ^ ghr_x[IDX_W-1:0];

    rsp_vld_d = accept & ~kill;
    rsp_hit_d = i_btb_hit;
    uflow_d   = i_cmt_vld & ~fifo_nempty;

    unused_bits = ^{i_pred_pc[MXLEN-1:IDX_W+2], i_pred_pc[1:0], ghr_x, head_ghr[GHR_W-1]};
  end

  // Control registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ghr_q      <= '0;
      arch_ghr_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_hit_q  <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      ghr_q      <= ghr_d;
      arch_ghr_q <= arch_ghr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_hit_q  <= rsp_hit_d;
      uflow_q    <= uflow_d;
    end
  end

  // Pattern table: trained from the counter value captured at prediction time
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CNT_RST;
    end else if (cmt_fire) begin
      pht_q[head_idx] <= sat_cnt(head_cnt, i_cmt_taken);
    end
  end

  // Response stage: synchronous table read, returns the pre-write value
  always_ff @(posedge i_clk) begin
    rsp_idx_q <= req_idx;
    rsp_cnt_q <= pht_q[req_idx];
  end

  // In-flight FIFO payload
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_idx_q[tail_q] <= rsp_idx_q;
      fifo_cnt_q[tail_q] <= rsp_cnt_q;
      fifo_ghr_q[tail_q] <= ghr_q;
    end
  end

endmodule
